alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one 32-bit ALU instance between two requesters, e.g. the integer datapath and a branch/address helper.
- Arbitrates round-robin (or fixed priority), latches the winner's operands, runs the ALU, and holds the registered result until the owner accepts it.
- One operation in flight at a time. Sits between the requesters and the ALU they would otherwise duplicate.

Parameters:
- FAIR, 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: operation of requester i is accepted this cycle; at most one bit set.
- req_a  in  64  operand A; requester i on bits [32i+31:32i].
- req_b  in  64  operand B; same packing as req_a.
- req_ctrl  in  6  ALU op; requester i on bits [3i+2:3i].
- rsp_valid  out  2  bit i: result for requester i is held on rsp_out/rsp_zero.
- rsp_ready  in  2  bit i: requester i takes the result.
- rsp_out  out  32  registered ALU result.
- rsp_zero  out  1  registered ALU zero flag.
- busy  out  1  high in EXEC or RESP.
- owner  out  1  index of the requester currently being served.

Behaviour:
- ALU ops via ctrl: 000 AND, 001 OR, 010 ADD, 110 SUB, any other code SLT (signed A<B gives 1, else 0).
- zero = (result == 0). ctrl is passed to the ALU unmodified; undefined codes give the SLT result, with no error.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = winner among asserted req_valid bits; req_ready[grant] = 1 combinationally.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
  - If any req_valid is set: latch a/b/ctrl of the winner, set owner = grant, go to EXEC.
  - Otherwise stay in IDLE with req_ready = 00.
- EXEC (1 cycle):
  - ALU evaluates the latched operands.
  - rsp_out/rsp_zero registers load the ALU outputs.
  - Go to RESP.
- RESP:
  - rsp_valid[owner] = 1; rsp_out, rsp_zero and owner are held stable.
  - On rsp_ready[owner]: clear rsp_valid and go to IDLE.
  - rsp_ready of the non-owner is ignored.
  - req_ready = 00.
- Latency and throughput:
  - Accept at edge N gives rsp_valid high from cycle N+2.
  - With rsp_ready held high, a new accept is possible at edge N+3 (one op per 3 cycles).
- Arbitration, FAIR=1:
  - 1-bit priority pointer; the pointer's requester wins when both are valid.
  - On every accept the pointer moves to the other requester.
  - A single valid requester always wins, regardless of the pointer.
- Arbitration, FAIR=0: requester 0 wins whenever req_valid[0] is set.
- Requests arriving during EXEC/RESP are not accepted; the requester holds them and they are arbitrated in the next IDLE.
- rsp_valid is never set for a requester that was not granted.
- Reset values:
  - state IDLE, pointer 0, owner 0, busy 0.
  - rsp_valid 00, rsp_out 0, rsp_zero 0, req_ready 00.
  - Latched operands 0.
- Reset mid-operation: the in-flight op is discarded and no response is issued. rsp_valid is 00 the cycle after the reset edge.
- rsp_out keeps its last value in IDLE; it is not cleared after a response.

Decomposition:
- Shared package: ALU op constants (OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111) and state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- One sub-module: alu_rr_pick, the combinational 2-way winner selection from req_valid, pointer and FAIR.
- The ALU itself is instantiated directly (32-bit A/B, 3-bit ctrl, Out, zero).

Test Plan:
- Reset, then req_valid=01 with a=5, b=3, ctrl=010 -> req_ready=01; two cycles later rsp_valid=01, rsp_out=8, rsp_zero=0.
- req_valid=10 with a=7, b=7, ctrl=110, rsp_ready low for 4 cycles -> rsp_valid=10 held with rsp_out=0, rsp_zero=1 stable; clears the cycle after rsp_ready=10.
- FAIR=1, both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1, one accept every 3 cycles. FAIR=0 under the same stimulus -> requester 0 granted every time.
- SLT: a=32'hFFFFFFFF, b=1, ctrl=111 -> rsp_out=1. Then a=1, b=32'hFFFFFFFF, ctrl=011 (undefined code, SLT path) -> rsp_out=0, rsp_zero=1.
- Assert rst during EXEC -> next cycle state IDLE, rsp_valid=00, busy=0, pointer=0, and no response ever appears for the dropped op.
- Requester 1 raises req_valid while requester 0 is in RESP -> req_ready stays 00 until the response is taken; then requester 1 is granted in IDLE.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU op codes, FSM encoding and helpers.
package alu_share_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU: AND, OR, ADD, SUB, with every other ctrl code falling through to signed SLT.
module alu
  import alu_share_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] out,
  output logic              zero
);

  logic slt;

  always_comb begin
    slt = ($signed(a) < $signed(b));
    out = '0;
    case (ctrl)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_ADD:  out = a + b;
      OP_SUB:  out = a - b;
      default: out = {{(DATA_W-1){1'b0}}, slt};
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational 2-way winner selection: round-robin on a 1-bit pointer, or fixed priority to requester 0.
module alu_rr_pick
  import alu_share_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic               pointer,
  output logic               grant,
  output logic               any
);

  always_comb begin
    any   = |valid;
    grant = 1'b0;
    if (FAIR) begin
      // Contention resolves to the pointer; a lone requester wins outright.
      if (valid[0] && valid[1]) begin
        grant = pointer;
      end else begin
        grant = valid[1];
      end
    end else begin
      grant = ~valid[0] & valid[1];
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one ALU: arbitrate in IDLE, compute in EXEC, hold the result in RESP until taken.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*CTRL_W-1:0]   req_ctrl,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]           rsp_out,
  output logic                        rsp_zero,
  output logic                        busy,
  output logic                        owner
);

  state_t              state_reg, state_next;
  logic                pointer_reg, pointer_next;
  logic                owner_reg, owner_next;
  logic [DATA_W-1:0]   a_reg, a_next;
  logic [DATA_W-1:0]   b_reg, b_next;
  logic [CTRL_W-1:0]   ctrl_reg, ctrl_next;
  logic [DATA_W-1:0]   rsp_out_reg, rsp_out_next;
  logic                rsp_zero_reg, rsp_zero_next;

  logic [DATA_W-1:0]   a_slot    [NUM_REQ];
  logic [DATA_W-1:0]   b_slot    [NUM_REQ];
  logic [CTRL_W-1:0]   ctrl_slot [NUM_REQ];

  logic                grant;
  logic                any_valid;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_zero;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_slot[gi]    = req_a[gi*DATA_W +: DATA_W];
      assign b_slot[gi]    = req_b[gi*DATA_W +: DATA_W];
      assign ctrl_slot[gi] = req_ctrl[gi*CTRL_W +: CTRL_W];
    end
  endgenerate

  alu_rr_pick #(
    .FAIR (FAIR)
  ) u_pick (
    .valid   (req_valid),
    .pointer (pointer_reg),
    .grant   (grant),
    .any     (any_valid)
  );

  alu u_alu (
    .a    (a_reg),
    .b    (b_reg),
    .ctrl (ctrl_reg),
    .out  (alu_out),
    .zero (alu_zero)
  );

  always_comb begin
    state_next    = state_reg;
    pointer_next  = pointer_reg;
    owner_next    = owner_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    ctrl_next     = ctrl_reg;
    rsp_out_next  = rsp_out_reg;
    rsp_zero_next = rsp_zero_reg;
    req_ready     = '0;
    rsp_valid     = '0;

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          req_ready    = onehot2(grant);
          a_next       = a_slot[grant];
          b_next       = b_slot[grant];
          ctrl_next    = ctrl_slot[grant];
          owner_next   = grant;
          // Hand priority to the requester that was just passed over.
          pointer_next = ~grant;
          state_next   = EXEC;
        end
      end
      EXEC: begin
        rsp_out_next  = alu_out;
        rsp_zero_next = alu_zero;
        state_next    = RESP;
      end
      RESP: begin
        rsp_valid = onehot2(owner_reg);
        if (rsp_ready[owner_reg]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pointer_reg  <= 1'b0;
      owner_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      ctrl_reg     <= '0;
      rsp_out_reg  <= '0;
      rsp_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pointer_reg  <= pointer_next;
      owner_reg    <= owner_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      ctrl_reg     <= ctrl_next;
      rsp_out_reg  <= rsp_out_next;
      rsp_zero_reg <= rsp_zero_next;
    end
  end

  assign rsp_out  = rsp_out_reg;
  assign rsp_zero = rsp_zero_reg;
  assign busy     = (state_reg != IDLE);
  assign owner    = owner_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a round-robin instance and a fixed-priority instance on shared stimulus.
module tb_alu_share_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [63:0]  req_a;
  logic [63:0]  req_b;
  logic [5:0]   req_ctrl;
  logic [1:0]   rsp_ready;

  logic [1:0]   req_ready,  req_ready_fp;
  logic [1:0]   rsp_valid,  rsp_valid_fp;
  logic [31:0]  rsp_out,    rsp_out_fp;
  logic         rsp_zero,   rsp_zero_fp;
  logic         busy,       busy_fp;
  logic         owner,      owner_fp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.FAIR(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .busy      (busy),
    .owner     (owner)
  );

  alu_share_arb #(.FAIR(1'b0)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready_fp),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid_fp),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out_fp),
    .rsp_zero  (rsp_zero_fp),
    .busy      (busy_fp),
    .owner     (owner_fp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic idx, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    req_a    = idx ? {a, 32'h0} : {32'h0, a};
    req_b    = idx ? {b, 32'h0} : {32'h0, b};
    req_ctrl = idx ? {c, 3'b000} : {3'b000, c};
  endtask

  // One complete operation from IDLE back to IDLE with immediate rsp_ready.
  task automatic do_op(input logic idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] c, input logic [31:0] exp_out, input logic exp_zero,
                       input string name);
    logic [1:0] oh;
    oh = idx ? 2'b10 : 2'b01;
    load(idx, a, b, c);
    req_valid = oh;
    #1;
    checks++;
    if (req_ready !== oh) begin
      failures++;
      $display("FAIL %s req_ready got=%b want=%b", name, req_ready, oh);
    end
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (rsp_valid !== oh || rsp_out !== exp_out || rsp_zero !== exp_zero || owner !== idx) begin
      failures++;
      $display("FAIL %s rsp got valid=%b out=%h zero=%b owner=%b want valid=%b out=%h zero=%b owner=%b",
               name, rsp_valid, rsp_out, rsp_zero, owner, oh, exp_out, exp_zero, idx);
    end
    rsp_ready = oh;
    tick();
    rsp_ready = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_release got valid=%b busy=%b want valid=00 busy=0", name, rsp_valid, busy);
    end
    $display("op %s req=%0d a=%h b=%h ctrl=%b out=%h zero=%b", name, idx, a, b, c, rsp_out, rsp_zero);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a = '0;
    req_b = '0;
    req_ctrl = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || busy !== 1'b0 || owner !== 1'b0 ||
        rsp_out !== 32'h0 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset got valid=%b ready=%b busy=%b owner=%b out=%h zero=%b want all zero",
               rsp_valid, req_ready, busy, owner, rsp_out, rsp_zero);
    end
    $display("reset done");
  endtask

  task automatic test_basic_add();
    tick();
    do_op(1'b0, 32'd5, 32'd3, 3'b010, 32'd8, 1'b0, "add_5_3");
  endtask

  task automatic test_hold();
    load(1'b1, 32'd7, 32'd7, 3'b110);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL hold_accept req_ready got=%b want=10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b01;  // non-owner ready must be ignored
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 2'b10 || rsp_out !== 32'h0 || rsp_zero !== 1'b1 || owner !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_cycle%0d got valid=%b out=%h zero=%b owner=%b busy=%b want 10 0 1 1 1",
                 i, rsp_valid, rsp_out, rsp_zero, owner, busy);
      end
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL hold_release rsp_valid got=%b want=00", rsp_valid);
    end
    $display("hold sub 7-7 held 4 cycles out=%h", rsp_out);
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_oh;
    logic [31:0] exp_res;
    req_a     = {32'd10, 32'd10};
    req_b     = {32'd4, 32'd4};
    req_ctrl  = {3'b110, 3'b010};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_oh  = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_res = (i % 2 == 1) ? 32'd6 : 32'd14;
      checks++;
      if (req_ready !== exp_oh || req_ready_fp !== 2'b01) begin
        failures++;
        $display("FAIL fair_grant%0d got rr=%b fp=%b want rr=%b fp=01", i, req_ready, req_ready_fp, exp_oh);
      end
      tick();
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1 || req_ready_fp !== 2'b00) begin
        failures++;
        $display("FAIL fair_exec%0d got ready=%b busy=%b fp_ready=%b want 00 1 00", i, req_ready, busy, req_ready_fp);
      end
      tick();
      checks++;
      if (rsp_valid !== exp_oh || rsp_out !== exp_res || rsp_valid_fp !== 2'b01 || rsp_out_fp !== 32'd14) begin
        failures++;
        $display("FAIL fair_rsp%0d got valid=%b out=%0d fp_valid=%b fp_out=%0d want %b %0d 01 14",
                 i, rsp_valid, rsp_out, rsp_valid_fp, rsp_out_fp, exp_oh, exp_res);
      end
      $display("fair op%0d rr_valid=%b rr_out=%0d fp_valid=%b fp_out=%0d", i, rsp_valid, rsp_out, rsp_valid_fp, rsp_out_fp);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
  endtask

  task automatic test_slt();
    do_op(1'b0, 32'hFFFF_FFFF, 32'h1, 3'b111, 32'h1, 1'b0, "slt_neg");
    do_op(1'b0, 32'h1, 32'hFFFF_FFFF, 3'b011, 32'h0, 1'b1, "slt_undef");
    do_op(1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, 32'h00F0_000F, 1'b0, "and");
    do_op(1'b0, 32'hF000_0001, 32'h0000_0100, 3'b001, 32'hF000_0101, 1'b0, "or");
  endtask

  task automatic test_reset_mid();
    do_op(1'b1, 32'd4, 32'd5, 3'b010, 32'd9, 1'b0, "pre_reset");
    load(1'b0, 32'd1, 32'd2, 3'b010);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    rst = 1'b1;  // state is EXEC here
    tick();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || owner !== 1'b0 || rsp_out !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid got valid=%b busy=%b owner=%b out=%h want 00 0 0 0", rsp_valid, busy, owner, rsp_out);
    end
    req_a = {32'd1, 32'd1};
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rst_pointer req_ready got=%b want=01", req_ready);
    end
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_rsp%0d got valid=%b busy=%b want 00 0", i, rsp_valid, busy);
      end
    end
    $display("reset mid-op dropped response");
  endtask

  task automatic test_late_request();
    load(1'b0, 32'd20, 32'd1, 3'b110);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    req_a[63:32] = 32'd3;
    req_b[63:32] = 32'd3;
    req_ctrl[5:3] = 3'b010;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready !== 2'b00) begin
        failures++;
        $display("FAIL late_blocked%0d req_ready got=%b want=00", i, req_ready);
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 2'b01 || rsp_out !== 32'd19) begin
      failures++;
      $display("FAIL late_rsp0 got valid=%b out=%0d want 01 19", rsp_valid, rsp_out);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL late_grant1 req_ready got=%b want=10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (rsp_valid !== 2'b10 || rsp_out !== 32'd6 || owner !== 1'b1) begin
      failures++;
      $display("FAIL late_rsp1 got valid=%b out=%0d owner=%b want 10 6 1", rsp_valid, rsp_out, owner);
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    $display("late request served after owner response out=%0d", rsp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_hold();
    test_fairness();
    test_slt();
    test_reset_mid();
    test_late_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
